// File: rtl/updown_sweep_ctrl.sv
// Sweep sequencer for an external 16-bit up/down counter: load, count toward target, handshake done.
// Define SEQ_PINGPONG_EN to add cfg_reps and back-and-forth reversals between the end points.
module updown_sweep_ctrl #(
  parameter int WIDTH = 16
`ifdef SEQ_PINGPONG_EN
  ,
  parameter int REPS_W = 8
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  input  logic [WIDTH-1:0] cfg_start,
  input  logic [WIDTH-1:0] cfg_end,
`ifdef SEQ_PINGPONG_EN
  input  logic [REPS_W-1:0] cfg_reps,
`endif
  input  logic [WIDTH-1:0] cnt_value,
  output logic             ld_cnt,
  output logic             updn_cnt,
  output logic             count_enb,
  output logic [WIDTH-1:0] data_in,
  output logic             busy,
  output logic             done
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] RUN  = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]       state_reg;
  logic [WIDTH-1:0] target_reg;
  logic [WIDTH-1:0] data_in_reg;
  logic             ld_reg;
  logic             updn_reg;
  logic             busy_reg;
  logic             done_reg;
  logic             at_target;

`ifdef SEQ_PINGPONG_EN
  logic [WIDTH-1:0]  end_reg;
  logic [REPS_W-1:0] reps_reg;
`endif

  assign at_target = (cnt_value == target_reg);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      target_reg  <= '0;
      data_in_reg <= '0;
      ld_reg      <= 1'b1;
      updn_reg    <= 1'b1;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
`ifdef SEQ_PINGPONG_EN
      end_reg     <= '0;
      reps_reg    <= '0;
`endif
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start) begin
            data_in_reg <= cfg_start;
            target_reg  <= cfg_end;
            updn_reg    <= (cfg_end >= cfg_start);
`ifdef SEQ_PINGPONG_EN
            end_reg     <= cfg_end;
            reps_reg    <= cfg_reps;
`endif
            ld_reg      <= 1'b0;
            busy_reg    <= 1'b1;
            state_reg   <= LOAD;
          end
        end
        LOAD: begin
          ld_reg <= 1'b1;
          if (abort) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else begin
            state_reg <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy_reg  <= 1'b0;
            state_reg <= IDLE;
          end else if (!pause && at_target) begin
`ifdef SEQ_PINGPONG_EN
            // data_in_reg still holds the latched start value, so it doubles as the return point
            if (reps_reg != '0) begin
              reps_reg   <= reps_reg - REPS_W'(1);
              updn_reg   <= ~updn_reg;
              target_reg <= (target_reg == end_reg) ? data_in_reg : end_reg;
            end else begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end
`else
            done_reg  <= 1'b1;
            state_reg <= DONE;
`endif
          end
        end
        DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          ld_reg    <= 1'b1;
          busy_reg  <= 1'b0;
          state_reg <= IDLE;
        end
      endcase
    end
  end

  // An abort during LOAD must suppress the load strobe in that very cycle, hence the OR.
  assign ld_cnt    = ld_reg | abort;
  assign count_enb = (state_reg == RUN) && !pause && !abort && !at_target;
  assign updn_cnt  = updn_reg;
  assign data_in   = data_in_reg;
  assign busy      = busy_reg;
  assign done      = done_reg;

endmodule
